// File: rtl/sram_rw_ctrl_if.sv
// Request/response bus between a requester and sram_rw_ctrl; rsp_err exists only with SRAM_RSP_ERR_EN.
// master = requester side, slave = controller side.
interface sram_rw_ctrl_if #(
  parameter int ROWS = 16,
  parameter int COLS = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
`ifdef SRAM_RSP_ERR_EN
  logic            rsp_err;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/sram_rw_ctrl.sv
// Sequences wordlines/bitlines of a ROWS x COLS split-port SRAM; one request at a time.
// Write busy WR_CYC+2 cycles; read response PRE_CYC+ACC_CYC+1 cycles after handshake.
// req_ready only in IDLE, no queueing. Define SRAM_RSP_ERR_EN to add rsp_err.
module sram_rw_ctrl #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int WR_CYC  = 2,
  parameter int PRE_CYC = 1,
  parameter int ACC_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_rw_ctrl_if.slave      bus,
  output logic [ROWS-1:0]    row_wr,
  output logic [ROWS-1:0]    row_rd,
  output logic [COLS-1:0]    bl_wr,
  output logic [COLS-1:0]    blb_wr,
  output logic               pre_rd,
  output logic               sae,
  input  logic [COLS-1:0]    bl_rd,
  input  logic [COLS-1:0]    blb_rd
);
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAXC = (WR_CYC > PRE_CYC) ? ((WR_CYC > ACC_CYC) ? WR_CYC : ACC_CYC)
                                           : ((PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC);
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [AW:0]     ROWS_W  = (AW + 1)'(ROWS);
  localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_PRE, R_ACC, R_RSP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] wdata_q, wdata_d;
  logic [COLS-1:0] rdata_q, rdata_d;
  logic            in_range;
  logic [ROWS-1:0] row_sel;
  logic            wr_last, pre_last, acc_last;
`ifdef SRAM_RSP_ERR_EN
  logic            err_q, err_d;
`endif

  // Out-of-range rows keep the full timing but never raise a wordline.
  assign in_range = {1'b0, addr_q} < ROWS_W;
  assign row_sel  = in_range ? (ROW_ONE << addr_q) : '0;
  assign wr_last  = cnt_q == CW'(WR_CYC - 1);
  assign pre_last = cnt_q == CW'(PRE_CYC - 1);
  assign acc_last = cnt_q == CW'(ACC_CYC - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_RSP_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        state_d = bus.req_we ? W_SETUP : R_PRE;
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: if (wr_last) state_d = W_HOLD; else cnt_d = cnt_q + CW'(1);
      W_HOLD:  state_d = IDLE;
      R_PRE:   if (pre_last) state_d = R_ACC; else cnt_d = cnt_q + CW'(1);
      R_ACC: begin
        if (acc_last) begin
          // A column reads 1 only on a clean bl=1/blb=0 split.
          rdata_d = in_range ? (bl_rd & ~blb_rd) : '0;
`ifdef SRAM_RSP_ERR_EN
          err_d   = !in_range || (|(bl_rd ~^ blb_rd));
`endif
          state_d = R_RSP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_RSP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SRAM_RSP_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.rsp_err = err_q;
`endif

  // Array drives decode straight from state_q so reset drops them asynchronously.
  always_comb begin
    row_wr = '0;
    row_rd = '0;
    bl_wr  = '0;
    blb_wr = '0;
    pre_rd = 1'b0;
    sae    = 1'b0;
    case (state_q)
      W_SETUP, W_HOLD: begin
        bl_wr  = wdata_q;
        blb_wr = ~wdata_q;
      end
      W_PULSE: begin
        bl_wr  = wdata_q;
        blb_wr = ~wdata_q;
        row_wr = row_sel;
      end
      R_PRE: pre_rd = 1'b1;
      R_ACC: begin
        row_rd = row_sel;
        sae    = acc_last;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == R_RSP);
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Random + directed bench for sram_rw_ctrl with a behavioural array, timeline checker and response scoreboard.
module tb_sram_rw_ctrl;
  localparam int ROWS    = 12;
  localparam int COLS    = 8;
  localparam int WR_CYC  = 2;
  localparam int PRE_CYC = 1;
  localparam int ACC_CYC = 2;
  localparam int AW      = 4;

  typedef struct {
    logic [COLS-1:0] data;
    logic            err;
  } exp_t;

  logic clk, rst_n;
  logic [ROWS-1:0] row_wr, row_rd;
  logic [COLS-1:0] bl_wr, blb_wr, bl_rd, blb_rd;
  logic pre_rd, sae;

  sram_rw_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  sram_rw_ctrl #(.ROWS(ROWS), .COLS(COLS), .WR_CYC(WR_CYC), .PRE_CYC(PRE_CYC), .ACC_CYC(ACC_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .row_wr(row_wr), .row_rd(row_rd), .bl_wr(bl_wr), .blb_wr(blb_wr),
    .pre_rd(pre_rd), .sae(sae), .bl_rd(bl_rd), .blb_rd(blb_rd)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [COLS-1:0] arr_mem [ROWS];   // the "analog" array, written only through the DUT
  logic [COLS-1:0] ref_mem [ROWS];   // reference contents, written from requests
  exp_t sb_q[$];

  logic [COLS-1:0] nxt_amb, nxt_ambv, act_amb, act_ambv;

  bit              act;
  int              t0;
  logic            a_we;
  logic [AW-1:0]   a_addr;
  logic [COLS-1:0] a_wd;
  logic [COLS-1:0] held;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Array model: writes whichever row is pulsed, reads the selected row, precharged otherwise.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < ROWS; i++)
      if (row_wr[i]) arr_mem[i] = bl_wr;
  end

  always_comb begin
    bl_rd  = '1;
    blb_rd = '1;
    for (int i = 0; i < ROWS; i++)
      if (row_rd[i]) begin
        bl_rd  = arr_mem[i];
        blb_rd = ~arr_mem[i];
      end
    if (row_rd != '0) begin
      bl_rd  = (bl_rd  & ~act_amb) | (act_amb & act_ambv);
      blb_rd = (blb_rd & ~act_amb) | (act_amb & act_ambv);
    end
  end

  // Monitor: cycle timeline derived from the handshake cycle, plus response scoreboard.
  initial forever begin
    logic            e_rdy, e_pre, e_sae, e_rv;
    logic [ROWS-1:0] e_rw, e_rr, oh;
    logic [COLS-1:0] e_bl, e_blb;
    int              k, dur;
    bit              inr;
    exp_t            e;
    @(negedge clk);
    if (!rst_n) begin
      act = 0;
      sb_q.delete();
      held = '0;
      chk("reset_ready", bus.req_ready, 1);
      chk("reset_drives", {row_wr, row_rd, bl_wr, blb_wr, pre_rd, sae}, 0);
      chk("reset_rsp", {bus.rsp_valid, bus.rsp_rdata}, 0);
    end else begin
      e_rdy = 1; e_pre = 0; e_sae = 0; e_rv = 0;
      e_rw = '0; e_rr = '0; e_bl = '0; e_blb = '0;
      if (act) begin
        k   = cyc - t0;
        dur = a_we ? WR_CYC + 2 : PRE_CYC + ACC_CYC + 1;
        inr = int'(a_addr) < ROWS;
        oh  = '0;
        if (inr) oh[a_addr] = 1'b1;
        if (k > dur) act = 0;
        else begin
          e_rdy = 0;
          if (a_we) begin
            e_bl  = a_wd;
            e_blb = ~a_wd;
            if (k >= 2 && k <= WR_CYC + 1) e_rw = oh;
          end else begin
            e_pre = (k <= PRE_CYC);
            if (k > PRE_CYC && k <= PRE_CYC + ACC_CYC) e_rr = oh;
            e_sae = (k == PRE_CYC + ACC_CYC);
            e_rv  = (k == dur);
          end
        end
      end
      chk("req_ready", bus.req_ready, e_rdy);
      chk("row_wr", row_wr, e_rw);
      chk("row_rd", row_rd, e_rr);
      chk("bl_wr", bl_wr, e_bl);
      chk("blb_wr", blb_wr, e_blb);
      chk("pre_rd", pre_rd, e_pre);
      chk("sae", sae, e_sae);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      if (bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.data);
`ifdef SRAM_RSP_ERR_EN
          chk("rsp_err", bus.rsp_err, e.err);
`endif
          held = e.data;
        end
      end else begin
        chk("rdata_hold", bus.rsp_rdata, held);
      end
      if (bus.req_valid && bus.req_ready) begin
        act      = 1;
        t0       = cyc;
        a_we     = bus.req_we;
        a_addr   = bus.req_addr;
        a_wd     = bus.req_wdata;
        act_amb  = nxt_amb;
        act_ambv = nxt_ambv;
      end
    end
  end

  task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [COLS-1:0] wd,
                        input logic [COLS-1:0] amb, input logic [COLS-1:0] ambv, input bit hold);
    bit   ok;
    bit   inr;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    nxt_amb       = amb;
    nxt_ambv      = ambv;
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    chk("accept", ok, 1);
    inr = int'(addr) < ROWS;
    if (ok) begin
      if (we) begin
        if (inr) ref_mem[addr] = wd;
      end else begin
        e.data = inr ? (ref_mem[addr] & ~amb) : '0;
        e.err  = !inr || (amb != '0);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [COLS-1:0] v;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    nxt_amb = '0; nxt_ambv = '0; act_amb = '0; act_ambv = '0;
    for (int i = 0; i < ROWS; i++) begin
      v = COLS'($urandom);
      arr_mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset while the read wordline is up: everything drops at once, no response follows.
    do_req(1'b0, 4'd3, '0, '0, '0, 1'b0);
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      ok = (row_rd != '0);
    end
    chk("reach_r_acc", ok, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_row_rd", row_rd, 0);
    chk("rst_pre_sae", {pre_rd, sae}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus.req_ready, 1);

    do_req(1'b1, 4'd5, 8'hA5, '0, '0, 1'b0);          // write 5 = A5
    repeat (2) @(posedge clk);
    #1;
    do_req(1'b0, 4'd5, '0, '0, '0, 1'b0);             // read 5 -> A5
    repeat (6) @(posedge clk);
    #1;
    do_req(1'b1, 4'd0, 8'hFF, '0, '0, 1'b1);          // back-to-back, valid held
    do_req(1'b0, 4'd0, '0, '0, '0, 1'b0);
    do_req(1'b0, 4'd13, '0, '0, '0, 1'b0);            // out of range -> 0
    do_req(1'b0, 4'd5, '0, 8'h04, 8'hFF, 1'b0);       // column 2 ambiguous -> A1

    for (int t = 0; t < 300; t++) begin
      logic [COLS-1:0] amb;
      amb = ($urandom_range(0, 3) == 0) ? COLS'($urandom) : '0;
      do_req(1'($urandom), AW'($urandom_range(0, 15)), COLS'($urandom), amb, COLS'($urandom),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
